// File: rtl/img_pkg.sv
// Shared types and constants for the image address responder and its sweeper.
package img_pkg;

  localparam int unsigned IMG_WIDTH_DEF  = 41;
  localparam int unsigned IMG_HEIGHT_DEF = 50;
  localparam int unsigned SWEEP_X_DEF    = 25;
  localparam int unsigned SWEEP_Y_DEF    = 25;
  localparam int unsigned DATA_W_DEF     = 8;

  typedef logic [DATA_W_DEF-1:0] pix_t;

  typedef struct packed {
    pix_t data;
    logic last;
  } resp_t;

  // Width of a linear address covering a w x h image.
  function automatic int unsigned addr_w(input int unsigned w, input int unsigned h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/img_addr_responder_if.sv
// Coordinate request, RAM read and pixel response signals of the responder.
interface img_addr_responder_if
  import img_pkg::*;
#(
  parameter int unsigned W_X    = $clog2(IMG_WIDTH_DEF),
  parameter int unsigned W_Y    = $clog2(IMG_HEIGHT_DEF),
  parameter int unsigned W_A    = addr_w(IMG_WIDTH_DEF, IMG_HEIGHT_DEF),
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              addr_valid;
  logic              addr_ready;
  logic [W_X-1:0]    x;
  logic [W_Y-1:0]    y;

  logic              mem_rd_en;
  logic [W_A-1:0]    mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              pix_last;

  // Responder side.
  modport slave (
    input  addr_valid, x, y, mem_rdata, pix_ready,
    output addr_ready, mem_rd_en, mem_addr, pix_valid, pix_data, pix_last
  );

  // Sweeper / RAM / evaluator side.
  modport master (
    output addr_valid, x, y, mem_rdata, pix_ready,
    input  addr_ready, mem_rd_en, mem_addr, pix_valid, pix_data, pix_last
  );

endinterface

// File: rtl/pix_fifo.sv
// Synchronous FIFO with occupancy count; push is visible on the following cycle.
module pix_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/img_addr_responder.sv
// Converts (x, y) requests to image-RAM reads and returns pixels in order,
// tagging the last pixel of each SWEEP_X*SWEEP_Y window.
// Optional build macro OOB_CLAMP_EN: clamp out-of-range coordinates and raise
// a sticky err_oob; otherwise addresses wrap and err_oob is tied low.
module img_addr_responder
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned SWEEP_X    = SWEEP_X_DEF,
  parameter int unsigned SWEEP_Y    = SWEEP_Y_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  img_addr_responder_if.slave  bus,
  output logic                 err_oob
);

  localparam int unsigned W_X   = $clog2(IMG_WIDTH);
  localparam int unsigned W_Y   = $clog2(IMG_HEIGHT);
  localparam int unsigned W_A   = addr_w(IMG_WIDTH, IMG_HEIGHT);
  localparam int unsigned WIN   = SWEEP_X * SWEEP_Y;
  localparam int unsigned W_WIN = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned W_CNT = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } rsp_t;

  logic             en_q, en_d;
  logic             inflight_q, inflight_d;
  logic             last_q, last_d;
  logic [W_WIN-1:0] win_q, win_d;

  logic             fire;
  logic             win_end;
  logic [W_X-1:0]   x_eff;
  logic [W_Y-1:0]   y_eff;
  logic [W_A-1:0]   addr_lin;
  logic [W_CNT-1:0] fifo_count;
  logic             fifo_empty;
  logic             pop;
  rsp_t             push_r;
  rsp_t             head_r;

`ifdef OOB_CLAMP_EN
  logic oob;
  logic err_q, err_d;

  // Clamp coordinates into the image and flag any out-of-range handshake.
  always_comb begin
    x_eff = bus.x;
    y_eff = bus.y;
    oob   = 1'b0;
    if (32'(bus.x) >= IMG_WIDTH) begin
      x_eff = W_X'(IMG_WIDTH - 1);
      oob   = 1'b1;
    end
    if (32'(bus.y) >= IMG_HEIGHT) begin
      y_eff = W_Y'(IMG_HEIGHT - 1);
      oob   = 1'b1;
    end
    err_d = err_q | (fire & oob);
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_oob = err_q;
`else
  assign x_eff   = bus.x;
  assign y_eff   = bus.y;
  assign err_oob = 1'b0;
`endif

  assign addr_lin = W_A'(y_eff) * W_A'(IMG_WIDTH) + W_A'(x_eff);

  // Credit: a read launched last cycle already owns a FIFO slot.
  assign bus.addr_ready = en_q & ((fifo_count + W_CNT'(inflight_q)) < W_CNT'(FIFO_DEPTH));
  assign fire           = bus.addr_valid & bus.addr_ready;
  assign bus.mem_rd_en  = fire;
  assign bus.mem_addr   = fire ? addr_lin : '0;

  assign win_end = (win_q == W_WIN'(WIN - 1));

  // Next-state for enable, in-flight tracking, tag pipeline and window counter.
  always_comb begin
    en_d       = 1'b1;
    inflight_d = fire;
    last_d     = fire & win_end;
    win_d      = win_q;
    if (fire) win_d = win_end ? '0 : win_q + W_WIN'(1);
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      inflight_q <= 1'b0;
      last_q     <= 1'b0;
      win_q      <= '0;
    end else begin
      en_q       <= en_d;
      inflight_q <= inflight_d;
      last_q     <= last_d;
      win_q      <= win_d;
    end
  end

  assign push_r.data = bus.mem_rdata;
  assign push_r.last = last_q;
  assign pop         = bus.pix_valid & bus.pix_ready;

  pix_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (W_CNT)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .wdata (push_r),
    .pop   (pop),
    .rdata (head_r),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.pix_valid = ~fifo_empty;
  assign bus.pix_data  = fifo_empty ? '0 : head_r.data;
  assign bus.pix_last  = fifo_empty ? 1'b0 : head_r.last;

endmodule

// File: tb/tb_img_addr_responder.sv
// Scoreboard bench for img_addr_responder (default parameters).
`timescale 1ns/1ps
module tb_img_addr_responder;
  import img_pkg::*;

  localparam int unsigned IW = 41;
  localparam int unsigned IH = 50;
  localparam int unsigned SX = 25;
  localparam int unsigned SY = 25;
  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;
  // Hand-derived: clog2(41)=6, clog2(50)=6, clog2(2050)=12.
  localparam int unsigned WX = 6;
  localparam int unsigned WY = 6;
  localparam int unsigned WA = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic err_oob;

  img_addr_responder_if #(.W_X(WX), .W_Y(WY), .W_A(WA), .DATA_W(DW)) bus ();

  img_addr_responder #(
    .IMG_WIDTH (IW), .IMG_HEIGHT (IH), .SWEEP_X (SX), .SWEEP_Y (SY),
    .DATA_W (DW), .FIFO_DEPTH (FD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_oob (err_oob)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_f(input logic [11:0] a);
    return a[7:0] ^ 8'hF0;
  endfunction

  // RAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= ram_f(bus.mem_addr);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  resp_t exp_q[$];
  int    win_cnt = 0;

  // Monitor state
  int         pops = 0;
  int         lasts = 0;
  bit         stalled = 0;
  logic [7:0] st_data;
  logic       st_last;
  bit         watch = 0;
  int         watch_pops = 0;
  int         watch_target = 0;
  int         bubbles = 0;

  // Monitor: compares each accepted pixel against the scoreboard, checks hold under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("hold_valid", bus.pix_valid, 1);
        chk("hold_data", bus.pix_data, st_data);
        chk("hold_last", bus.pix_last, st_last);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pix: got data 0x%0h with empty scoreboard at %0t", bus.pix_data, $time);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          chk("pix_data", bus.pix_data, e.data);
          chk("pix_last", bus.pix_last, e.last);
        end
        pops++;
        if (bus.pix_last) lasts++;
        if (watch) watch_pops++;
      end else if (watch && watch_pops > 0 && watch_pops < watch_target) begin
        bubbles++;
      end
      stalled = bus.pix_valid && !bus.pix_ready;
      st_data = bus.pix_data;
      st_last = bus.pix_last;
    end
  end

  // Present one request; returns at posedge+1 after handshake or after tmo cycles.
  task automatic req(input int xx, input int yy, input int exp_a, input int tmo, output bit ok);
    resp_t r;
    bus.addr_valid = 1'b1;
    bus.x = WX'(xx);
    bus.y = WY'(yy);
    ok = 0;
    for (int c = 0; c < tmo && !ok; c++) begin
      @(negedge clk);
      if (bus.addr_ready) begin
        ok = 1;
        chk("mem_rd_en", bus.mem_rd_en, 1);
        chk("mem_addr", bus.mem_addr, exp_a);
        r.data = ram_f(12'(exp_a));
        r.last = (win_cnt == SX * SY - 1);
        exp_q.push_back(r);
        win_cnt = (win_cnt == SX * SY - 1) ? 0 : win_cnt + 1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int tmo);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < tmo) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr_ready"}, bus.addr_ready, 0);
    chk({tag, "_mem_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_pix_valid"}, bus.pix_valid, 0);
    chk({tag, "_pix_data"}, bus.pix_data, 0);
    chk({tag, "_pix_last"}, bus.pix_last, 0);
    chk({tag, "_err_oob"}, err_oob, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int accepted;
    int lasts0;

    bus.addr_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.pix_ready = 1'b1;

    #2;
    chk_reset_outputs("rst");

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", bus.addr_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", bus.addr_ready, 1);

    // Single request (3,2): 2*41+3 = 85, pixel 0x55^0xF0 = 0xA5, two cycles later.
    req(3, 2, 85, 10, ok);
    bus.addr_valid = 1'b0;
    chk("single_ok", ok, 1);
    @(negedge clk);
    chk("lat1_valid", bus.pix_valid, 0);
    @(negedge clk);
    chk("lat2_valid", bus.pix_valid, 1);
    chk("lat2_data", bus.pix_data, 8'hA5);
    @(posedge clk);
    #1;
    drain(20);

    // Corners: 49*41+40 = 2049, (0,0) = 0.
    req(40, 49, 2049, 10, ok);
    chk("corner_hi_ok", ok, 1);
    req(0, 0, 0, 10, ok);
    chk("corner_lo_ok", ok, 1);
    bus.addr_valid = 1'b0;
    drain(20);

    // Backpressure: only FIFO_DEPTH=4 requests fit while pix_ready is low.
    bus.pix_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      req(i, 5, 5 * 41 + i, 6, ok);
      if (ok) accepted++;
    end
    chk("bp_accepted", accepted, 4);
    @(negedge clk);
    chk("bp_ready_low", bus.addr_ready, 0);
    bus.addr_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.pix_ready = 1'b1;
    for (int i = 4; i < 10; i++) begin
      req(i, 5, 5 * 41 + i, 20, ok);
      chk("bp_late_ok", ok, 1);
    end
    bus.addr_valid = 1'b0;
    drain(40);

    // Out of range (45,60).
    chk("oob_pre_err", err_oob, 0);
`ifdef OOB_CLAMP_EN
    req(45, 60, 2049, 10, ok);
    bus.addr_valid = 1'b0;
    @(negedge clk);
    chk("oob_err_next", err_oob, 1);
    repeat (5) @(negedge clk);
    chk("oob_err_sticky", err_oob, 1);
`else
    // W_A = 12, so wrap is modulo 4096: 60*41+45 = 2505.
    req(45, 60, 2505, 10, ok);
    bus.addr_valid = 1'b0;
    @(negedge clk);
    chk("oob_err_next", err_oob, 0);
    repeat (5) @(negedge clk);
    chk("oob_err_sticky", err_oob, 0);
`endif
    chk("oob_ok", ok, 1);
    @(posedge clk);
    #1;
    drain(20);

    // Reset with one read in flight and three buffered.
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(10 + i, 7, 7 * 41 + 10 + i, 10, ok);
      chk("pre_rst_ok", ok, 1);
    end
    bus.addr_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    win_cnt = 0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", bus.addr_ready, 1);

    // Two full windows back-to-back: no bubbles, last tag on every 625th beat.
    lasts0 = lasts;
    watch_pops = 0;
    watch_target = 2 * SX * SY;
    bubbles = 0;
    watch = 1;
    for (int w = 0; w < 2; w++) begin
      for (int yy = 0; yy < int'(SY); yy++) begin
        for (int xx = 0; xx < int'(SX); xx++) begin
          req(xx, yy, yy * 41 + xx, 10, ok);
          chk("stream_ok", ok, 1);
        end
      end
    end
    bus.addr_valid = 1'b0;
    drain(40);
    watch = 0;
    chk("stream_bubbles", bubbles, 0);
    chk("stream_pops", watch_pops, 2 * SX * SY);
    chk("stream_lasts", lasts - lasts0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
